// File: rtl/TEST_TYPES.sv
// Shared types for the struct array writer/reader pair: element struct and reader FSM state.
package TEST_TYPES;

    typedef struct packed {
        logic stuff;
    } a_struct_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/struct_array_reader_if.sv
// Capture/stream bus between the array writer (master) and struct_array_reader (slave).
interface struct_array_reader_if #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic                           load_valid;
    logic                           load_ready;
    TEST_TYPES::a_struct_t [N-1:0]  a_in;
    logic                           out_valid;
    logic                           out_ready;
    TEST_TYPES::a_struct_t          out_elem;
    logic [IW-1:0]                  out_index;
    logic                           done;
    logic [7:0]                     err_count;

    modport master (
        output load_valid, a_in, out_ready,
        input  load_ready, out_valid, out_elem, out_index, done, err_count
    );

    modport slave (
        input  load_valid, a_in, out_ready,
        output load_ready, out_valid, out_elem, out_index, done, err_count
    );
endinterface

// File: rtl/struct_array_reader.sv
// Captures a packed struct array and streams it out one element per handshake.
// Optional STRUCT_ARRAY_READER_CHECK_EN adds a stuff-vs-index-parity mismatch counter.
module struct_array_reader
    import TEST_TYPES::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    struct_array_reader_if.slave  bus
);

    state_t                state_q, state_d;
    a_struct_t [N-1:0]     arr_q, arr_d;
    logic [IW-1:0]         index_q, index_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            arr_q   <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            index_q <= index_d;
        end
    end

    // Outputs are gated by state so IDLE/DONE/reset always present zeroed element and index.
    always_comb begin
        state_d        = state_q;
        arr_d          = arr_q;
        index_d        = index_q;
        bus.load_ready = 1'b0;
        bus.out_valid  = 1'b0;
        bus.done       = 1'b0;
        bus.out_elem   = '0;
        bus.out_index  = '0;
        unique case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    arr_d   = bus.a_in;
                    index_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_elem  = arr_q[index_q];
                bus.out_index = index_q;
                if (bus.out_ready) begin
                    // Last element leaves SEND without wrapping the index.
                    if (index_q == IW'(N - 1)) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STRUCT_ARRAY_READER_CHECK_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       xfer;
    logic [7:0] err_q, err_d;

    assign xfer = bus.out_valid && bus.out_ready;

    // Each element's stuff bit is expected to equal the parity of its index.
    always_comb begin
        err_d = err_q;
        if (xfer && (bus.out_elem.stuff != bus.out_index[0])) begin
            err_d = sat_inc8(err_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_struct_array_reader.sv
// Directed scoreboard bench for struct_array_reader with N=4 and N=1 instances.
module tb_struct_array_reader;
    import TEST_TYPES::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    struct_array_reader_if #(.N(4), .IW(2)) bus4 ();
    struct_array_reader_if #(.N(1), .IW(1)) bus1 ();

    struct_array_reader #(.N(4), .IW(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    struct_array_reader #(.N(1), .IW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [1:0] idx;
        logic       stuff;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset4();
        chk("rst_load_ready", 32'(bus4.load_ready), 32'd1);
        chk("rst_out_valid",  32'(bus4.out_valid),  32'd0);
        chk("rst_done",       32'(bus4.done),       32'd0);
        chk("rst_err_count",  32'(bus4.err_count),  32'd0);
        chk("rst_out_elem",   32'(bus4.out_elem),   32'd0);
        chk("rst_out_index",  32'(bus4.out_index),  32'd0);
    endtask

    // Capture s into dut4 and push the expected stream; a_in is scrambled right after capture.
    task automatic load4(input logic [3:0] s);
        chk("load_ready_idle", 32'(bus4.load_ready), 32'd1);
        bus4.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus4.a_in[i].stuff = s[i];
            sb.push_back('{idx: 2'(i), stuff: s[i]});
        end
        @(posedge clk); #1;
        bus4.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) bus4.a_in[i].stuff = ~s[i];
    endtask

    task automatic cycle4(input logic rdy, input bit hammer, output bit saw_done, output bit xfer);
        exp_t e;
        saw_done = 1'b0;
        xfer     = 1'b0;
        bus4.out_ready = rdy;
        if (hammer) begin
            bus4.load_valid = 1'b1;
            for (int i = 0; i < 4; i++) bus4.a_in[i].stuff = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb[0];
            chk("out_valid",       32'(bus4.out_valid),      32'd1);
            chk("load_ready_send", 32'(bus4.load_ready),     32'd0);
            chk("out_index",       32'(bus4.out_index),      32'(e.idx));
            chk("out_stuff",       32'(bus4.out_elem.stuff), 32'(e.stuff));
            if (rdy) begin
`ifdef STRUCT_ARRAY_READER_CHECK_EN
                if ((e.stuff !== e.idx[0]) && (exp_err < 255)) exp_err++;
`endif
                void'(sb.pop_front());
                xfer = 1'b1;
            end
        end else begin
            saw_done = bus4.done;
            chk("done_pulse",      32'(bus4.done),       32'd1);
            chk("done_out_valid",  32'(bus4.out_valid),  32'd0);
            chk("done_load_ready", 32'(bus4.load_ready), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,0,0,...
    task automatic drain4(input int mode, input bit hammer);
        int cyc = 0;
        int last_xfer = -1;
        int done_cyc = -1;
        bit d, x;
        logic rdy;
        while (done_cyc < 0 && cyc < 40) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            cycle4(rdy, hammer, d, x);
            if (x) last_xfer = cyc;
            if (d) done_cyc = cyc;
            cyc++;
            if (sb.size() == 0 && !x && !d) break;
        end
        bus4.load_valid = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("done_after_last", 32'(done_cyc), 32'(last_xfer + 1));
        if (mode == 0) chk("done_5th_cycle", 32'(done_cyc), 32'd4);
        chk("idle_load_ready", 32'(bus4.load_ready), 32'd1);
        chk("idle_no_done",    32'(bus4.done),       32'd0);
        chk("idle_out_valid",  32'(bus4.out_valid),  32'd0);
        chk("err_count",       32'(bus4.err_count),  32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d, x;
        rst_n = 1'b0;
        bus4.load_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a_in = '0;
        bus1.load_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a_in = '0;
        @(posedge clk); #1;
        chk_reset4();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Alternating stuff, always ready
        load4(4'b1010);
        drain4(0, 1'b0);

        // Same load, backpressure
        load4(4'b1010);
        drain4(1, 1'b0);

        // All-ones: indices 0 and 2 mismatch when checking is built in
        load4(4'b1111);
        drain4(0, 1'b0);

        // load_valid and a_in toggled during SEND must be ignored
        load4(4'b0110);
        drain4(0, 1'b1);

        // Reset after two transfers abandons the burst
        load4(4'b0011);
        cycle4(1'b1, 1'b0, d, x);
        cycle4(1'b1, 1'b0, d, x);
        rst_n = 1'b0;
        #1;
        chk_reset4();
        sb.delete();
        exp_err = 0;
        @(negedge clk);
        chk("rst_hold_no_done", 32'(bus4.done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        load4(4'b0101);
        drain4(0, 1'b0);

        // N=1: single element, then done, then idle
        chk("n1_load_ready", 32'(bus1.load_ready), 32'd1);
        bus1.out_ready = 1'b1;
        bus1.load_valid = 1'b1;
        bus1.a_in[0].stuff = 1'b0;
        @(posedge clk); #1;
        bus1.load_valid = 1'b0;
        bus1.a_in[0].stuff = 1'b1;
        @(negedge clk);
        chk("n1_out_valid", 32'(bus1.out_valid),      32'd1);
        chk("n1_out_index", 32'(bus1.out_index),      32'd0);
        chk("n1_out_stuff", 32'(bus1.out_elem.stuff), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1_done",        32'(bus1.done),       32'd1);
        chk("n1_done_valid",  32'(bus1.out_valid),  32'd0);
        chk("n1_done_ready",  32'(bus1.load_ready), 32'd0);
        @(posedge clk); #1;
        chk("n1_idle_ready",  32'(bus1.load_ready), 32'd1);
        chk("n1_idle_done",   32'(bus1.done),       32'd0);
        chk("n1_err_count",   32'(bus1.err_count),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/struct_array_reader.md
STRUCT_ARRAY_READER -- requirements
Module: struct_array_reader

Interface
REQ-001 Parameter N, default 4, number of elements in the packed struct array; N >= 1 SHALL be supported.
REQ-002 Parameter IW, default $clog2(N) with minimum 1, SHALL set the index width.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  array capture request.
REQ-006 load_ready  output  1  block SHALL accept a capture only when this is high.
REQ-007 a_in  input  N x a_struct_t (packed)  array supplied by the writer.
REQ-008 out_valid  output  1  out_elem and out_index SHALL be valid while this is high.
REQ-009 out_ready  input  1  downstream accepts the element.
REQ-010 out_elem  output  a_struct_t  current element.
REQ-011 out_index  output  IW  index of out_elem.
REQ-012 done  output  1  one-cycle pulse after the last element is accepted.
REQ-013 err_count  output  8  saturating pattern-mismatch counter (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-015 In IDLE, load_ready=1 and out_valid=0; load_valid=1 SHALL register a_in into an internal array, clear the index to 0 and move to SEND on the next edge.
REQ-016 In SEND, out_valid=1, out_elem=captured[index], out_index=index; load_ready=0, and load_valid SHALL be ignored.
REQ-017 A transfer occurs when out_valid and out_ready are both high; index SHALL increment by 1 per transfer.
REQ-018 While out_ready=0, out_elem and out_index SHALL hold stable, with no index change.
REQ-019 A transfer at index N-1 SHALL move to DONE, with no wrap to 0 inside SEND; for N=1 the first transfer goes straight to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, load_ready=0 and out_valid=0, then return to IDLE.
REQ-021 Capture-to-first-out_valid latency SHALL be 1 cycle; minimum burst length SHALL be N+2 cycles, including the DONE and IDLE cycles.
REQ-022 Changes on a_in after capture SHALL NOT affect emitted elements.

Reset
REQ-023 Asserting rst_n low SHALL immediately force IDLE, index=0, load_ready=1, out_valid=0, done=0, err_count=0, out_elem=0 and out_index=0.
REQ-024 Reset during SEND SHALL abandon the burst, with no done pulse; a new capture is allowed on the first edge after deassertion.

Configuration
REQ-025 With STRUCT_ARRAY_READER_CHECK_EN defined, each transfer SHALL compare out_elem.stuff with out_index[0]; a mismatch SHALL increment err_count, saturating at 255.
REQ-026 Without STRUCT_ARRAY_READER_CHECK_EN, err_count SHALL be constant 0 and no compare logic SHALL exist.

Structure
REQ-027 a_struct_t (packed, field logic stuff) SHALL live in the shared package TEST_TYPES and be imported by both this block and the writer.
REQ-028 The FSM state enum SHALL live in the same package as a typedef.
REQ-029 The block SHALL be a single module with no sub-module.

Verification
REQ-030 N=4, a_in stuff bits {3:1,2:0,1:1,0:0}, out_ready held 1 -> out_valid for 4 consecutive cycles with indices 0,1,2,3 and stuff 0,1,0,1, done on the 5th cycle, err_count=0.
REQ-031 Same load, out_ready toggled 1,0,0,1,... -> each element held stable while out_ready=0, order unchanged, exactly one done pulse.
REQ-032 CHECK_EN defined, a_in stuff all 1 for N=4 -> err_count=2 after done (indices 0 and 2 mismatch).
REQ-033 rst_n pulsed low after 2 transfers -> outputs at reset values at once, no done; a reload afterwards restarts at index 0.
REQ-034 N=1, a_in stuff=0 -> one transfer at index 0, then done, then load_ready=1.
REQ-035 load_valid=1 and a_in changed during SEND -> ignored, original captured data emitted.
